// File: rtl/posterize_pipe.sv
// Two-stage posterize filter for packed {R,G,B} pixels: S1 clamps the kept-bit
// count and adds a 2x2 ordered-dither offset, S2 keeps the top bits and replicates them.
module posterize_pipe #(
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int DEF_BITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         filter_en,
  input  logic [2:0]                   cfg_bits,
  input  logic                         cfg_dither,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [R_W+G_W+B_W-1:0]       s_data,
  input  logic                         s_sof,
  input  logic [9:0]                   x_local,
  input  logic [9:0]                   y_local,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [R_W+G_W+B_W-1:0]       m_data,
  output logic                         m_sof
);

  localparam int PIX_W = R_W + G_W + B_W;

  logic             sh_en;
  logic [2:0]       sh_k;
  logic             sh_dith;
  logic             eff_en;
  logic [2:0]       eff_k;
  logic             eff_dith;
  logic [1:0]       bayer;
  logic             adv1;
  logic             adv2;
  logic             accept;
  logic             s1_valid;
  logic             s1_sof;
  logic             s1_en;
  logic [PIX_W-1:0] s2_next;
  logic             unused_coord;

  assign unused_coord = ^{x_local[9:1], y_local[9:1]};

  assign adv2    = !m_valid || m_ready;
  assign adv1    = !s1_valid || adv2;
  assign s_ready = adv1;
  assign accept  = s_valid && s_ready;

  // A start-of-frame beat already runs with the configuration it is latching.
  assign eff_en   = s_sof ? filter_en  : sh_en;
  assign eff_k    = s_sof ? cfg_bits   : sh_k;
  assign eff_dith = s_sof ? cfg_dither : sh_dith;

  // Bayer matrix [[0,2],[3,1]] indexed [row][column].
  always_comb begin
    bayer = 2'd0;
    case ({y_local[0], x_local[0]})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_en   <= 1'b1;
      sh_k    <= 3'(DEF_BITS);
      sh_dith <= 1'b0;
    end else if (accept && s_sof) begin
      sh_en   <= filter_en;
      sh_k    <= cfg_bits;
      sh_dith <= cfg_dither;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_en    <= 1'b0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sof <= s_sof;
        s1_en  <= eff_en;
      end
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    localparam int W   = (ch == 0) ? R_W : (ch == 1) ? G_W : B_W;
    localparam int W1  = W + 1;
    localparam int LSB = (ch == 0) ? (G_W + B_W) : (ch == 1) ? B_W : 0;

    logic [W-1:0] c_in;
    logic [W-1:0] sat;
    logic [W:0]   off;
    logic [W:0]   sum;
    logic [2:0]   kc;
    logic [W-1:0] s1_val;
    logic [2:0]   s1_kc;
    logic [W-1:0] rep;

    assign c_in = s_data[LSB +: W];

    always_comb begin
      kc = eff_k;
      if (eff_k == 3'd0)
        kc = 3'd1;
      else if (int'(eff_k) > W)
        kc = 3'(W);
    end

    // Offset scales the Bayer value to just below the first dropped bit.
    always_comb begin
      int d;
      d   = W - int'(kc);
      off = '0;
      if (eff_dith) begin
        if (d >= 2)
          off = W1'(bayer) << (d - 2);
        else if (d == 1)
          off = W1'(bayer >> 1);
      end
      sum = {1'b0, c_in} + off;
      sat = sum[W] ? '1 : sum[W-1:0];
    end

    // NOTE: datapath registers are reset too, so m_data reads zero out of
    // reset and no stale pixel can leak into the first post-reset beat.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_val <= '0;
        s1_kc  <= 3'd1;
      end else if (adv1 && accept) begin
        s1_val <= eff_en ? sat : c_in;
        s1_kc  <= kc;
      end
    end

    // Replicate the top kc bits downward from the MSB, wrapping every kc bits.
    always_comb begin
      int j;
      rep = '0;
      j   = W - 1;
      for (int i = W - 1; i >= 0; i--) begin
        rep[i] = s1_val[j];
        if (j <= W - int'(s1_kc))
          j = W - 1;
        else
          j = j - 1;
      end
    end

    assign s2_next[LSB +: W] = s1_en ? rep : s1_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_data  <= '0;
    end else if (adv2) begin
      m_valid <= s1_valid;
      if (s1_valid) begin
        m_sof  <= s1_sof;
        m_data <= s2_next;
      end
    end
  end

endmodule

// File: tb/tb_posterize_pipe.sv
// Scoreboard bench for posterize_pipe: a driver pushes expected beats from a
// plain-arithmetic model, a monitor pops and compares on every output transfer.
module tb_posterize_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        filter_en = 1'b1;
  logic [2:0]  cfg_bits = 3'd2;
  logic        cfg_dither = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic [9:0]  x_local = '0;
  logic [9:0]  y_local = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        m_sof;

  always #5 clk = ~clk;

  posterize_pipe #(.R_W(5), .G_W(6), .B_W(5), .DEF_BITS(2)) dut (
    .clk(clk), .reset(reset), .filter_en(filter_en), .cfg_bits(cfg_bits),
    .cfg_dither(cfg_dither), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .x_local(x_local), .y_local(y_local),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof)
  );

  typedef struct packed {
    logic        sof;
    logic [15:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    total_wait = 0;
  bit    rand_ready = 0;

  bit    m_en = 1;
  int    m_k = 2;
  bit    m_dith = 0;
  int    bay[2][2] = '{'{0, 2}, '{3, 1}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int unsigned model_ch(input int unsigned c, input int w, input int k,
                                           input bit dith, input int b);
    int kc, d;
    int unsigned off, s, mx, q, r;
    kc  = (k < 1) ? 1 : ((k > w) ? w : k);
    d   = w - kc;
    off = 0;
    if (dith) begin
      if (d >= 2)      off = b * (1 << (d - 2));
      else if (d == 1) off = b / 2;
    end
    s  = c + off;
    mx = (1 << w) - 1;
    if (s > mx) s = mx;
    q = s >> d;
    r = 0;
    for (int i = 0; i < w; i++) r = (r << 1) | ((q >> (kc - 1 - (i % kc))) & 1);
    return r;
  endfunction

  function automatic logic [15:0] model_pixel(input logic [15:0] d, input logic x0, input logic y0);
    int b;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] bl;
    if (!m_en) return d;
    b  = bay[y0][x0];
    r  = 5'(model_ch(d[15:11], 5, m_k, m_dith, b));
    g  = 6'(model_ch(d[10:5],  6, m_k, m_dith, b));
    bl = 5'(model_ch(d[4:0],   5, m_k, m_dith, b));
    return {r, g, bl};
  endfunction

  // Called at posedge+#1; returns at posedge+#1 right after the acceptance edge.
  task automatic drive_beat(input logic [15:0] d, input logic sof, input logic [9:0] x,
                            input logic [9:0] y, input logic fen, input logic [2:0] bits,
                            input logic dith, input bit use_exp, input logic [15:0] exp);
    int    waited;
    beat_t bt;
    s_valid = 1; s_data = d; s_sof = sof; x_local = x; y_local = y;
    filter_en = fen; cfg_bits = bits; cfg_dither = dith;
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 0, 1);
        s_valid = 0;
        return;
      end
    end
    total_wait += waited;
    if (sof) begin
      m_en = fen; m_k = int'(bits); m_dith = dith;
    end
    bt.sof  = sof;
    bt.data = use_exp ? exp : model_pixel(d, x[0], y[0]);
    exp_q.push_back(bt);
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every transfer and checks output stability under stall.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_sof;
    beat_t       e;
    prev_stall = 0; prev_data = '0; prev_sof = 0;
    forever begin
      @(negedge clk);
      if (reset && prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_sof", m_sof, prev_sof);
      end
      if (reset && m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", m_data, 32'hDEAD_BEEF);
        else begin
          e = exp_q.pop_front();
          check("data", m_data, e.data);
          check("sof", m_sof, e.sof);
        end
      end
      prev_stall = reset && m_valid && !m_ready;
      prev_data  = m_data;
      prev_sof   = m_sof;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_data", m_data, 0);
    check("rst_m_sof", m_sof, 0);
    reset = 1;
    @(posedge clk); #1;

    // Basic quantize with default configuration and latency.
    drive_beat(16'h8410, 1, 10'd0, 10'd0, 1, 3'd2, 0, 1, 16'hAD55);
    @(negedge clk);
    check("latency_cycle1_idle", m_valid, 0);
    @(negedge clk);
    check("latency_cycle2_valid", m_valid, 1);
    @(posedge clk); #1;

    // Dither and saturation.
    drive_beat(16'h3800, 1, 10'd1, 10'd1, 1, 3'd2, 1, 1, 16'h5000);
    drive_beat(16'h3800, 0, 10'd0, 10'd0, 1, 3'd2, 1, 1, 16'h0000);
    drive_beat(16'hFFFF, 0, 10'd0, 10'd1, 1, 3'd2, 1, 1, 16'hFFFF);

    // Config boundary: clamp to 1, mid-frame change ignored, 7 gives passthrough.
    drive_beat(16'h8000, 1, 10'd0, 10'd0, 1, 3'd0, 0, 1, 16'hF800);
    drive_beat(16'h8000, 0, 10'd0, 10'd0, 1, 3'd7, 0, 1, 16'hF800);
    drive_beat(16'h1234, 1, 10'd3, 10'd2, 1, 3'd7, 1, 1, 16'h1234);
    drive_beat(16'hBEEF, 1, 10'd1, 10'd0, 0, 3'd1, 1, 1, 16'hBEEF);
    drain();

    // Backpressure: five beats, m_ready low in cycles 3-6.
    total_wait = 0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          drive_beat(16'h1111 * 16'(i + 1), (i == 0), 10'd0, 10'd0, 0, 3'd2, 0, 1,
                     16'h1111 * 16'(i + 1));
      end
      begin
        for (int cyc = 1; cyc <= 8; cyc++) begin
          m_ready = !(cyc >= 3 && cyc <= 6);
          @(posedge clk); #1;
        end
        m_ready = 1;
      end
    join
    check("bp_s_ready_deasserted", (total_wait > 0), 1);
    drain();

    // Reset with both stages full.
    m_ready = 0;
    drive_beat(16'h0F0F, 1, 10'd0, 10'd0, 1, 3'd7, 1, 1, 16'h0F0F);
    drive_beat(16'hF0F0, 0, 10'd0, 10'd0, 1, 3'd7, 1, 1, 16'hF0F0);
    check("pre_reset_full", {m_valid, s_ready}, 2'b10);
    reset = 0;
    #1;
    check("mid_reset_m_valid", m_valid, 0);
    check("mid_reset_s_ready", s_ready, 1);
    check("mid_reset_m_data", m_data, 0);
    exp_q.delete();
    m_en = 1; m_k = 2; m_dith = 0;
    @(posedge clk); #1;
    reset = 1;
    m_ready = 1;
    drive_beat(16'h8410, 0, 10'd1, 10'd1, 0, 3'd7, 1, 1, 16'hAD55);
    drain();

    // Randomized traffic against the reference model.
    rand_ready = 1;
    drive_beat(16'($urandom), 1, 10'($urandom), 10'($urandom), 1, 3'($urandom), 1, 0, '0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      drive_beat(16'($urandom), ($urandom_range(0, 11) == 0), 10'($urandom), 10'($urandom),
                 ($urandom_range(0, 4) != 0), 3'($urandom), 1'($urandom), 0, '0);
    end
    drain();
    rand_ready = 0;
    m_ready = 1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
